// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Purpose  : Shared types and helpers for the iterative multiply/divide engine.
// Revision : 1.0
// ============================================================================
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;
  localparam int CNT_W        = $clog2(MULDIV_WIDTH);

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CALC  = 2'b01,
    FIX   = 2'b10,
    WRITE = 2'b11
  } state_t;

  function automatic logic op_is_div(input op_t o);
    return o[1];
  endfunction

  function automatic logic op_is_signed(input op_t o);
    return ~o[0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_signfix.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_signfix
// Purpose  : Restores result signs for signed ops and forces divide-by-zero.
// Revision : 1.0
// ============================================================================
module muldiv_signfix #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic             is_signed,
  input  logic             sa,
  input  logic             sb,
  input  logic             div0,
  input  logic [WIDTH-1:0] araw,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] fhi,
  output logic [WIDTH-1:0] flo
);

  logic [2*WIDTH-1:0] w_prod_neg;

  assign w_prod_neg = -{hi, lo};

  always_comb begin
    fhi = hi;
    flo = lo;
    if (is_div) begin
      // A zero divisor has no trap: quotient saturates, remainder is the raw dividend.
      if (div0) begin
        fhi = araw;
        flo = '1;
      end else if (is_signed) begin
        flo = (sa ^ sb) ? -lo : lo;
        fhi = sa ? -hi : hi;
      end
    end else if (is_signed && (sa ^ sb)) begin
      {fhi, flo} = w_prod_neg;
    end
  end

endmodule
`default_nettype wire

// File: rtl/iterative_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : iterative_muldiv
// Purpose  : One-bit-per-cycle MULT/MULTU/DIV/DIVU engine with HI/LO write.
// Revision : 1.0
// ============================================================================
module iterative_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             we,
  output logic [WIDTH-1:0] wdhi,
  output logic [WIDTH-1:0] wdlo
);

  localparam int c_cnt_w = $clog2(WIDTH);

  state_t             r_state, w_next;
  op_t                r_op;
  logic               r_sa, r_sb;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_hi, r_lo, r_opnd, r_araw;
  logic [WIDTH-1:0]   r_wdhi, r_wdlo;

  logic               w_accept, w_last, w_sub;
  logic [WIDTH-1:0]   w_amag, w_bmag, w_fhi, w_flo;
  logic [WIDTH:0]     w_x, w_y, w_sum;

  assign w_accept = start && !abort;
  assign w_last   = (r_cnt == c_cnt_w'(WIDTH - 1));

  // Magnitudes stay unsigned WIDTH bits, so |most-negative| is representable.
  assign w_amag = (op_is_signed(op) && a[WIDTH-1]) ? -a : a;
  assign w_bmag = (op_is_signed(op) && b[WIDTH-1]) ? -b : b;

  // Shared adder: MUL adds the multiplicand to HI, DIV subtracts the divisor
  // from the left-shifted remainder.
  assign w_sub = op_is_div(r_op);
  assign w_x   = w_sub ? {r_hi, r_lo[WIDTH-1]} : {1'b0, r_hi};
  assign w_y   = (w_sub || r_lo[0]) ? {1'b0, r_opnd} : '0;
  assign w_sum = w_x + (w_y ^ {(WIDTH+1){w_sub}}) + (WIDTH+1)'(w_sub);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = (r_state != IDLE);
    we     = 1'b0;
    case (r_state)
      IDLE:  if (w_accept) w_next = CALC;
      CALC:  if (abort) w_next = IDLE; else if (w_last) w_next = FIX;
      FIX:   w_next = abort ? IDLE : WRITE;
      WRITE: begin
        w_next = IDLE;
        we     = !abort;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_op   <= MULT;
      r_sa   <= 1'b0;
      r_sb   <= 1'b0;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_opnd <= '0;
      r_araw <= '0;
      r_wdhi <= '0;
      r_wdlo <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_op   <= op;
          r_sa   <= a[WIDTH-1];
          r_sb   <= b[WIDTH-1];
          r_araw <= a;
          r_cnt  <= '0;
          r_hi   <= '0;
          r_lo   <= op_is_div(op) ? w_amag : w_bmag;
          r_opnd <= op_is_div(op) ? w_bmag : w_amag;
        end
        CALC: begin
          r_cnt <= r_cnt + c_cnt_w'(1);
          if (w_sub) begin
            r_hi <= w_sum[WIDTH] ? w_x[WIDTH-1:0] : w_sum[WIDTH-1:0];
            r_lo <= {r_lo[WIDTH-2:0], ~w_sum[WIDTH]};
          end else begin
            r_hi <= w_sum[WIDTH:1];
            r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
          end
        end
        FIX: if (!abort) begin
          r_wdhi <= w_fhi;
          r_wdlo <= w_flo;
        end
        default: ;
      endcase
    end
  end

  muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
    .is_div    (op_is_div(r_op)),
    .is_signed (op_is_signed(r_op)),
    .sa        (r_sa),
    .sb        (r_sb),
    .div0      (r_opnd == '0),
    .araw      (r_araw),
    .hi        (r_hi),
    .lo        (r_lo),
    .fhi       (w_fhi),
    .flo       (w_flo)
  );

  assign wdhi = r_wdhi;
  assign wdlo = r_wdlo;

endmodule
`default_nettype wire

// File: tb/tb_iterative_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_iterative_muldiv
// Purpose  : Directed self-checking bench for iterative_muldiv.
// Revision : 1.0
// ============================================================================
module tb_iterative_muldiv;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  op_t         op = MULT;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, we;
  logic [31:0] wdhi, wdlo;

  int checks = 0;
  int errors = 0;

  iterative_muldiv #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .abort (abort),
    .busy  (busy),
    .we    (we),
    .wdhi  (wdhi),
    .wdlo  (wdlo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller is in cycle 0 (just after a rising edge); start is raised here.
  task automatic run(input string tag, input op_t o, input logic [31:0] av, input logic [31:0] bv,
                     input logic [31:0] ehi, input logic [31:0] elo, input int restart);
    int we_n, we_at, busy_bad;
    logic [31:0] hi, lo;
    we_n = 0; we_at = -1; busy_bad = 0; hi = '0; lo = '0;
    op = o; a = av; b = bv; start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (busy !== (k <= 34)) busy_bad++;
      if (we === 1'b1) begin
        we_n++; we_at = k; hi = wdhi; lo = wdlo;
      end
      start = (k == restart);
    end
    check({tag, ".lat"}, 64'(we_at), 64'd34);
    check({tag, ".wecnt"}, 64'(we_n), 64'd1);
    check({tag, ".busy"}, 64'(busy_bad), 64'd0);
    check({tag, ".hi"}, {32'd0, hi}, {32'd0, ehi});
    check({tag, ".lo"}, {32'd0, lo}, {32'd0, elo});
  endtask

  initial begin
    int we_n, we_at;
    logic [31:0] hi, lo;

    tick();
    tick();
    check("rst.busy", {63'd0, busy}, 64'd0);
    check("rst.we",   {63'd0, we},   64'd0);
    check("rst.wdhi", {32'd0, wdhi}, 64'd0);
    check("rst.wdlo", {32'd0, wdlo}, 64'd0);
    reset = 1'b1;
    tick();

    run("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
    run("mult_neg",  MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 0);
    run("mult_min",  MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0);
    run("div_neg",   DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    run("div_negb",  DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0);
    run("divu",      DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       0);
    run("div_ovf",   DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0);
    run("divu_z",    DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 0);
    run("div_z",     DIV,   32'hFFFFFFF7, 32'd0,        32'hFFFFFFF7, 32'hFFFFFFFF, 0);
    run("restart",   MULTU, 32'd1000,     32'd3000,     32'd0,        32'd3000000,  20);

    // Abort a MULT at cycle 10, restart at cycle 11, expect completion at 45.
    we_n = 0; we_at = -1; hi = '0; lo = '0;
    op = MULT; a = 32'd12345; b = 32'd678; start = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (we === 1'b1) begin
        we_n++; we_at = k; hi = wdhi; lo = wdlo;
      end
      if (k == 10) check("abort.busy10", {63'd0, busy}, 64'd1);
      if (k == 11) check("abort.busy11", {63'd0, busy}, 64'd0);
      start = 1'b0;
      abort = (k == 10);
      if (k == 11) begin
        op = MULTU; a = 32'd6; b = 32'd7; start = 1'b1;
      end
    end
    check("abort.wecnt", 64'(we_n), 64'd1);
    check("abort.lat",   64'(we_at), 64'd45);
    check("abort.lo",    {32'd0, lo}, 64'd42);
    check("abort.hi",    {32'd0, hi}, 64'd0);

    // Abort landing in WRITE must suppress the strobe.
    we_n = 0;
    op = DIVU; a = 32'd9; b = 32'd4; start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      start = 1'b0;
      abort = (k == 34);
      #1;
      if (we === 1'b1) we_n++;
      if (k == 35) check("wabort.busy35", {63'd0, busy}, 64'd0);
    end
    abort = 1'b0;
    check("wabort.wecnt", 64'(we_n), 64'd0);

    // Reset mid-CALC kills the op and clears outputs.
    we_n = 0;
    op = MULTU; a = 32'd3; b = 32'd5; start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (we === 1'b1) we_n++;
      if (k == 16) begin
        check("mrst.busy", {63'd0, busy}, 64'd0);
        check("mrst.we",   {63'd0, we},   64'd0);
        check("mrst.wdhi", {32'd0, wdhi}, 64'd0);
        check("mrst.wdlo", {32'd0, wdlo}, 64'd0);
      end
      start = 1'b0;
      reset = (k != 15);
    end
    check("mrst.wecnt", 64'(we_n), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
